instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, meaning the address tagged to the first emitted instruction.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request carries a field set to encode.
REQ-005 SHALL have port in_ready  output  1  encoder can accept a request.
REQ-006 SHALL have port imm_src  input  2  format: 00 I, 01 S, 10 B, 11 reserved.
REQ-007 SHALL have port imm  input  32  signed immediate value to pack.
REQ-008 SHALL have port base_instr  input  32  instruction carrying opcode, register and funct fields; its immediate bit positions are ignored.
REQ-009 SHALL have port out_valid  output  1  instr_out, out_err and out_addr are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the output.
REQ-011 SHALL have port instr_out  output  32  encoded instruction.
REQ-012 SHALL have port out_err  output  1  immediate was not representable, or imm_src was reserved.
REQ-013 SHALL have port out_addr  output  32  address tag of the current output word.

Function
REQ-014 A request SHALL transfer on a rising edge where in_valid && in_ready; an output SHALL transfer on a rising edge where out_valid && out_ready.
REQ-015 Each transferred request SHALL be encoded combinationally and written into a 2-entry in-order FIFO; out_valid SHALL rise on the edge that writes an empty FIFO, giving 1-cycle latency.
REQ-016 in_ready SHALL equal FIFO-not-full; a full FIFO SHALL NOT accept input even when a pop occurs in the same cycle. Simultaneous push and pop with 1 entry SHALL keep the count at 1.
REQ-017 Format I SHALL place imm[11:0] in bits [31:20].
REQ-018 Format S SHALL place imm[11:5] in bits [31:25] and imm[4:0] in bits [11:7].
REQ-019 Format B SHALL place imm[12] in bit 31, imm[10:5] in bits [30:25], imm[4:1] in bits [11:8] and imm[11] in bit 7.
REQ-020 All bits not named in REQ-017 to REQ-019 SHALL be copied from base_instr. For reserved imm_src, instr_out SHALL equal base_instr.
REQ-021 Range rules: I/S SHALL be in error outside [-2048, 2047]. B SHALL be in error outside [-4096, 4094] or when imm[0]=1. On error the truncated bits SHALL still be packed.
REQ-022 For every in-range request, decoding instr_out with the same imm_src SHALL sign-extend back to exactly imm (round-trip property).
REQ-023 out_addr SHALL start at ADDR_BASE and increase by 4 on each output transfer, wrapping modulo 2^32.
REQ-024 The outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-025 While rst is asserted, the FIFO SHALL be empty, out_valid=0, in_ready=0, instr_out=0, out_err=0 and out_addr=ADDR_BASE.
REQ-026 rst asserted mid-operation SHALL discard all pending entries immediately. in_ready SHALL return to 1 on the first clock edge after release.

Configuration
REQ-027 With INSTR_ENC_RANGE_CHECK_EN defined, out_err SHALL follow REQ-012 and REQ-021.
REQ-028 Without INSTR_ENC_RANGE_CHECK_EN, out_err SHALL be constant 0 and no range logic SHALL be synthesised; packing SHALL be unchanged.

Structure
REQ-029 The shared package cpu_pkg SHALL hold the imm_src constants IMM_I, IMM_S, IMM_B and IMM_RSVD, plus the range limits for each format.
REQ-030 The FIFO SHALL be a sub-module instr_enc_fifo: 2 entries, 65 bits wide (instruction + err + address-independent), with valid/ready on both sides.

Verification
REQ-031 I-type: imm_src=00, imm=-1, base_instr=0x00000013 -> instr_out=0xFFF00013, out_err=0, out_addr=ADDR_BASE.
REQ-032 S-type: imm_src=01, imm=8, base_instr=0x00002023 -> instr_out=0x00002423, out_err=0.
REQ-033 B-type: imm_src=10, imm=-4, base_instr=0x00000063 -> instr_out=0xFE000EE3, out_err=0. A second case with imm=3 -> out_err=1 (odd value).
REQ-034 Range: imm_src=00, imm=2048, base_instr=0x00000013 -> instr_out=0x80000013, out_err=1 with the macro defined and 0 without it.
REQ-035 Backpressure: out_ready=0 and three back-to-back requests -> in_ready drops after 2 accepts. Raising out_ready -> the three words emerge in order with out_addr 0x0, 0x4, 0x8.
REQ-036 Reset mid-operation: assert rst with 2 entries queued -> out_valid=0 asynchronously and out_addr=ADDR_BASE. The next request after release emerges with out_addr=ADDR_BASE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the immediate encoder.
// Contents: imm_src format codes, signed range limits per format, and the
// FIFO entry layout (instruction, error flag, address tag = 65 bits).
package cpu_pkg;

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_RSVD = 2'b11;

  // I and S share a 12-bit signed field; B is 13-bit signed with bit 0 implied zero
  localparam int signed IS_MIN = -2048;
  localparam int signed IS_MAX = 2047;
  localparam int signed B_MIN  = -4096;
  localparam int signed B_MAX  = 4094;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [31:0] addr;
  } enc_entry_t;

  localparam int ENC_W = $bits(enc_entry_t);

endpackage

// File: rtl/instr_enc_fifo.sv
// Two-entry in-order FIFO with valid/ready on both sides.
// Ports: clk, rst (async, active-high), in_valid/in_ready/in_data (write side),
// out_valid/out_ready/out_data (read side, head shown combinationally).
// in_ready is purely not-full: a full FIFO refuses input even if popped that cycle.
module instr_enc_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RISC-V style immediate encoder: packs imm into base_instr per format
// (I/S/B), flags unrepresentable immediates, and queues results in a
// 2-entry FIFO with an address tag that advances by 4 per emitted word.
// Ports: clk, rst (async, active-high); in_valid/in_ready, imm_src, imm,
// base_instr (request); out_valid/out_ready, instr_out, out_err, out_addr.
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN enables out_err; without
// it out_err is tied to 0 and no range logic exists.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic        out_err,
  output logic [31:0] out_addr
);

  logic [31:0] enc;
  logic        enc_err;
  logic        rdy_q;
  logic [31:0] tag_q;
  logic        fifo_in_ready;
  logic        push;
  enc_entry_t  wr_e, rd_e;

  always_comb begin
    enc = base_instr;
    case (imm_src)
      IMM_I: enc[31:20] = imm[11:0];
      IMM_S: begin
        enc[31:25] = imm[11:5];
        enc[11:7]  = imm[4:0];
      end
      IMM_B: begin
        enc[31]    = imm[12];
        enc[30:25] = imm[10:5];
        enc[11:8]  = imm[4:1];
        enc[7]     = imm[11];
      end
      default: ;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_comb begin
    case (imm_src)
      IMM_I, IMM_S: enc_err = ($signed(imm) < IS_MIN) || ($signed(imm) > IS_MAX);
      IMM_B:        enc_err = ($signed(imm) < B_MIN) || ($signed(imm) > B_MAX) || imm[0];
      default:      enc_err = 1'b1;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:13];
  assign enc_err       = 1'b0;
`endif

  // rdy_q keeps in_ready low through reset and lifts it on the first edge after release
  assign in_ready = rdy_q && fifo_in_ready;
  assign push     = in_valid && in_ready;

  // Tags are handed out at push time; since the FIFO is in-order and reset
  // clears both, this equals counting output transfers from ADDR_BASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      tag_q <= ADDR_BASE;
    end else begin
      rdy_q <= 1'b1;
      if (push) tag_q <= tag_q + 32'd4;
    end
  end

  assign wr_e = '{instr: enc, err: enc_err, addr: tag_q};

  instr_enc_fifo #(.W(ENC_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (fifo_in_ready),
    .in_data   (wr_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (rd_e)
  );

  assign instr_out = rd_e.instr;
  assign out_err   = rd_e.err;
  // When empty, show the tag the next word will carry
  assign out_addr  = out_valid ? rd_e.addr : tag_q;

endmodule
